// File: rtl/exe_muldiv.sv
// exe_muldiv: multi-cycle RV32M/RV64M execute unit.
// Radix-2 shift-add multiplier and restoring divider share one accumulator.
// Optional macro MULDIV_FAST_MUL_EN: multiplies complete through a single
// combinational multiplier (IDLE -> DONE), divides still iterate.
module exe_muldiv #(
    parameter int XLEN        = 32,
    parameter int RADDR_WIDTH = 5,
    parameter int CNT_WIDTH   = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [2:0]             funct3_i,
    input  logic [XLEN-1:0]        op1_i,
    input  logic [XLEN-1:0]        op2_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   flush_i,
    output logic                   busy_o,
    output logic                   stallreq_o,
    output logic                   done_o,
    output logic                   reg_we_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic [XLEN-1:0]        reg_wdata_o
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    // mul: {partial high, multiplier/low product}; div: {remainder, quotient}
    logic [2*XLEN-1:0]      acc_q, acc_d;
    // mul: multiplicand magnitude; div: divisor magnitude
    logic [XLEN-1:0]        opnd_q, opnd_d;
    logic [2:0]             f3_q, f3_d;
    logic [RADDR_WIDTH-1:0] rd_q, rd_d;
    logic                   s1_q, s1_d, s2_q, s2_d;
    logic [XLEN-1:0]        wdata_q, wdata_d;
    logic [RADDR_WIDTH-1:0] waddr_q, waddr_d;

    // Operand decode in IDLE
    logic            is_div, sgn1, sgn2, s1_in, s2_in;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, div_ovf, mul_zero;

    // Iteration datapath and result fix-up
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_rem_sh, div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, result;

    // Decode signedness, magnitudes and bypass cases of the incoming request
    always_comb begin
        is_div   = funct3_i[2];
        sgn1     = (funct3_i == 3'd1) || (funct3_i == 3'd2) ||
                   (funct3_i == 3'd4) || (funct3_i == 3'd6);
        sgn2     = (funct3_i == 3'd1) || (funct3_i == 3'd4) || (funct3_i == 3'd6);
        s1_in    = sgn1 & op1_i[XLEN-1];
        s2_in    = sgn2 & op2_i[XLEN-1];
        mag1     = s1_in ? (~op1_i + 1'b1) : op1_i;
        mag2     = s2_in ? (~op2_i + 1'b1) : op2_i;
        div_zero = is_div && (op2_i == '0);
        div_ovf  = ((funct3_i == 3'd4) || (funct3_i == 3'd6)) &&
                   (op1_i == MIN_NEG) && (op2_i == ALL_ONES);
        mul_zero = !is_div && ((op1_i == '0) || (op2_i == '0));
    end

    // One shift-add step and one restoring-divide step, plus the sign fix-up
    always_comb begin
        mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_rem_sh = acc_q[2*XLEN-1:XLEN-1];
        div_diff   = div_rem_sh - {1'b0, opnd_q};
        prod_fix   = (s1_q ^ s2_q) ? (~acc_q + 1'b1) : acc_q;
        quot_fix   = (s1_q ^ s2_q) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_fix    = s1_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
        case (f3_q)
            3'd0:       result = prod_fix[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       result = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5: result = quot_fix;
            default:    result = rem_fix;
        endcase
    end

    // Next-state logic: accept, iterate, complete; flush always returns to IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    f3_d   = funct3_i;
                    rd_d   = reg_waddr_i;
                    s1_d   = s1_in;
                    s2_d   = s2_in;
                    cnt_d  = '0;
                    opnd_d = is_div ? mag2 : mag1;
                    acc_d  = {{XLEN{1'b0}}, is_div ? mag1 : mag2};
                    state_d = S_CALC;
                    // Bypass cases preload the accumulator so that the normal
                    // DONE result selection yields the architectural answer.
                    if (div_zero) begin
                        acc_d   = {op1_i, ALL_ONES};
                        s1_d    = 1'b0;
                        s2_d    = 1'b0;
                        state_d = S_DONE;
                    end else if (div_ovf) begin
                        acc_d   = {{XLEN{1'b0}}, op1_i};
                        s1_d    = 1'b0;
                        s2_d    = 1'b0;
                        state_d = S_DONE;
                    end else if (mul_zero) begin
                        acc_d   = '0;
                        s1_d    = 1'b0;
                        s2_d    = 1'b0;
                        state_d = S_DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!is_div) begin
                        acc_d   = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                if (f3_q[2]) begin
                    if (!div_diff[XLEN])
                        acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    else
                        acc_d = {div_rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_WIDTH'(XLEN - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!flush_i) begin
                    wdata_d = result;
                    waddr_d = rd_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i)
            state_d = S_IDLE;
    end

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            wdata_q <= '0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
        end
    end

    // Status and write-back outputs; write-back holds its last value outside DONE
    always_comb begin
        busy_o      = (state_q != S_IDLE);
        stallreq_o  = ((state_q == S_IDLE) && start_i && !flush_i) || (state_q == S_CALC);
        done_o      = (state_q == S_DONE) && !flush_i;
        reg_we_o    = done_o && (rd_q != '0);
        reg_waddr_o = (state_q == S_DONE) ? rd_q   : waddr_q;
        reg_wdata_o = (state_q == S_DONE) ? result : wdata_q;
    end

endmodule
